// File: rtl/morph_pkg.sv
// morph_pkg: shared states, default geometry and border test for the morphology frame sequencer
package morph_pkg;
    typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, NEXT, DONE} state_e;
    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;
    localparam int NPIX = IMG_W_DEF * IMG_H_DEF;
    localparam int SKIP = IMG_W_DEF + 1;
    function automatic logic is_border(input int unsigned r, input int unsigned c,
                                       input int unsigned w, input int unsigned h);
        return r == 0 || c == 0 || r == h - 1 || c == w - 1;
    endfunction
endpackage

// File: rtl/morph_wr_tracker.sv
// morph_wr_tracker: skips filter warm-up outputs, tracks row/col and registers destination writes
// Ports: clr_i restarts a pass; filt_valid_i/filt_out_i filter result; border_zero_i masks edges;
//        wr_en_o/wr_addr_o/wr_data_o registered write; last_o final qualifying output; done_o all written
module morph_wr_tracker
    import morph_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              filt_valid_i,
    input  logic [7:0]        filt_out_i,
    input  logic              border_zero_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              last_o,
    output logic              done_o
);
    localparam int SKIP_P = IMG_W + 1;
    localparam int TOT = SKIP_P + IMG_W * IMG_H;
    localparam int CW = $clog2(TOT + 1);
    localparam int RW = $clog2(IMG_H);
    localparam int XW = $clog2(IMG_W);
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [XW-1:0] col_q, col_d;
    logic [ADDR_W-1:0] idx_q, idx_d, wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic wr_en_q, wr_en_d, take, go, col_end;
    // the valid counter saturates at TOT so surplus filter outputs are neither written nor wrap the position
    always_comb begin
        take      = filt_valid_i && vcnt_q != CW'(TOT);
        go        = take && vcnt_q >= CW'(SKIP_P);
        col_end   = col_q == XW'(IMG_W - 1);
        vcnt_d    = clr_i ? '0 : vcnt_q + CW'(take);
        col_d     = clr_i ? '0 : (go ? (col_end ? '0 : col_q + 1'b1) : col_q);
        row_d     = clr_i ? '0 : ((go && col_end) ? (row_q == RW'(IMG_H - 1) ? '0 : row_q + 1'b1) : row_q);
        idx_d     = clr_i ? '0 : idx_q + ADDR_W'(go);
        wr_en_d   = go && !clr_i;
        wr_addr_d = go ? idx_q : wr_addr_q;
        wr_data_d = !go ? wr_data_q :
                    (border_zero_i && is_border(32'(row_q), 32'(col_q), IMG_W, IMG_H)) ? '0 : filt_out_i;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vcnt_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            vcnt_q    <= vcnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign last_o    = go && vcnt_q == CW'(TOT - 1);
    assign done_o    = vcnt_q == CW'(TOT);
endmodule

// File: rtl/morph_frame_ctrl.sv
// morph_frame_ctrl: streams a frame through a 3x3 morphology filter for N ping-pong passes
// Ports: start/num_passes/border_zero job control; rd_* source RAM; filt_* filter interface;
//        wr_* destination RAM (buffer ~rd_buf); busy/frame_done/pass_idx status
module morph_frame_ctrl
    import morph_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 16,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PASS_W-1:0] num_passes,
    input  logic              border_zero,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              rd_buf,
    output logic              filt_en,
    output logic [7:0]        filt_data,
    input  logic              filt_valid,
    input  logic [7:0]        filt_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [PASS_W-1:0] pass_idx
);
    localparam int NPIX_P = IMG_W * IMG_H;
    state_e state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [PASS_W-1:0] pass_q, pass_d, npass_q, npass_d;
    logic rd_en_q, rd_buf_q, rd_buf_d, bz_q, bz_d, clr, last, done;
    // FLUSH spans W+2 cycles: the first carries the final pixel read in FEED, the rest the W+1 zeros
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        npass_d  = npass_q;
        bz_d     = bz_q;
        rd_buf_d = rd_buf_q;
        clr      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = FEED;
                cnt_d   = '0;
                pass_d  = '0;
                npass_d = num_passes == '0 ? PASS_W'(1) : num_passes;
                bz_d    = border_zero;
            end
            FEED: begin
                cnt_d   = cnt_q == ADDR_W'(NPIX_P - 1) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == ADDR_W'(NPIX_P - 1) ? FLUSH : FEED;
            end
            FLUSH: begin
                cnt_d   = cnt_q == ADDR_W'(IMG_W + 1) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == ADDR_W'(IMG_W + 1) ? DRAIN : FLUSH;
            end
            DRAIN: state_d = (last || done) ? NEXT : DRAIN;
            NEXT: begin
                clr      = 1'b1;
                rd_buf_d = ~rd_buf_q;
                pass_d   = pass_q + 1'b1;
                state_d  = pass_d < npass_q ? FEED : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pass_q   <= '0;
            npass_q  <= '0;
            bz_q     <= 1'b0;
            rd_buf_q <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            npass_q  <= npass_d;
            bz_q     <= bz_d;
            rd_buf_q <= rd_buf_d;
            rd_en_q  <= rd_en;
        end
    end
    assign rd_en      = state_q == FEED;
    assign rd_addr    = cnt_q;
    assign rd_buf     = rd_buf_q;
    assign filt_en    = rd_en_q || state_q == FLUSH;
    assign filt_data  = rd_en_q ? rd_data : 8'h00;
    assign busy       = state_q != IDLE;
    assign frame_done = state_q == DONE;
    assign pass_idx   = pass_q;
    morph_wr_tracker #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_trk (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .filt_valid_i (filt_valid),
        .filt_out_i   (filt_out),
        .border_zero_i(bz_q),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .last_o       (last),
        .done_o       (done)
    );
endmodule

// File: tb/tb_morph_frame_ctrl.sv
// tb_morph_frame_ctrl: scoreboard bench with RAM and OR-window filter models around morph_frame_ctrl
module tb_morph_frame_ctrl;
    localparam int W = 4, H = 4, N = W * H, SK = W + 1, LAT = 2;
    typedef logic [7:0] img_t [N];
    typedef struct { bit b; int a; logic [7:0] d; int p; } wr_t;
    logic clk = 0, rst = 1, start = 0, border_zero = 0;
    logic [3:0] num_passes = 0, pass_idx, rd_addr, wr_addr;
    logic [7:0] rd_data = 0, filt_out, filt_data, wr_data;
    logic filt_valid, rd_en, rd_buf, filt_en, wr_en, busy, frame_done;
    logic [7:0] mem [2][N];
    logic [7:0] in_px [N+SK];
    logic [LAT-1:0] pv = '0;
    logic [7:0] pd [LAT];
    wr_t sbq[$];
    int total = 0, bad = 0, nw = 0, ndone = 0, cyc = 0, last_wr = 0, en_cnt = 0;
    bit exp_rb = 0;
    assign filt_valid = pv[LAT-1];
    assign filt_out   = pd[LAT-1];

    morph_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(4), .PASS_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .num_passes(num_passes), .border_zero(border_zero),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_buf(rd_buf),
        .filt_en(filt_en), .filt_data(filt_data), .filt_valid(filt_valid), .filt_out(filt_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .pass_idx(pass_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // golden 3x3 dilation of a whole image, out-of-frame neighbours ignored
    function automatic img_t dil(input img_t a, input bit bz);
        img_t o;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                logic [7:0] v = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
                            v |= a[(r + dr) * W + c + dc];
                o[r * W + c] = (bz && (r == 0 || r == H - 1 || c == 0 || c == W - 1)) ? 8'h00 : v;
            end
        return o;
    endfunction

    function automatic img_t rimg();
        img_t r;
        for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        return r;
    endfunction

    // monitor, filter model and RAM model, all evaluated mid-cycle
    always @(negedge clk) begin : model
        wr_t e;
        int k, c;
        logic [7:0] o;
        if (rst) begin
            en_cnt = 0;
            pv = '0;
            for (int i = 0; i < LAT; i++) pd[i] = 0;
        end else begin
            if (wr_en) begin
                nw++;
                last_wr = cyc;
                if (sbq.size() == 0) chk("unexpected_wr", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("wr_buf", 32'(!rd_buf), 32'(e.b));
                    chk("wr_addr", 32'(wr_addr), e.a);
                    chk("wr_data", 32'(wr_data), 32'(e.d));
                    chk("pass_idx", 32'(pass_idx), e.p);
                end
            end
            if (frame_done) begin
                ndone++;
                chk("done_after_last_wr", cyc - last_wr, 1);
                chk("sb_empty_at_done", sbq.size(), 0);
            end
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = filt_en;
            pd[0] = 0;
            if (filt_en) begin
                k = en_cnt;
                in_px[k] = filt_data;
                c = k - SK;
                o = 8'h5A;
                if (c >= 0) begin
                    o = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if (c / W + dr >= 0 && c / W + dr < H && c % W + dc >= 0 && c % W + dc < W)
                                o |= in_px[c + dr * W + dc];
                end
                pd[0] = o;
                en_cnt = (k + 1) % (N + SK);
            end
            if (wr_en) mem[!rd_buf][wr_addr] = wr_data;
            if (rd_en) rd_data = mem[rd_buf][rd_addr];
        end
    end

    task automatic run_job(input img_t img, input int np, input bit bz, input bit mid_start, input bit abort);
        int n, w0, d0, t;
        img_t cur;
        wr_t e;
        n = np == 0 ? 1 : np;
        cur = img;
        chk("rd_buf_idle", 32'(rd_buf), 32'(exp_rb));
        for (int i = 0; i < N; i++) mem[exp_rb][i] = img[i];
        for (int p = 0; p < n; p++) begin
            cur = dil(cur, bz);
            for (int i = 0; i < N; i++) begin
                e.b = exp_rb ^ p[0] ^ 1'b1;
                e.a = i;
                e.d = cur[i];
                e.p = p;
                sbq.push_back(e);
            end
        end
        w0 = nw;
        d0 = ndone;
        @(negedge clk);
        start = 1; num_passes = 4'(np); border_zero = bz;
        @(negedge clk);
        start = 0; num_passes = 4'($urandom); border_zero = 1'($urandom);
        chk("busy_started", 32'(busy), 1);
        if (mid_start) begin
            repeat (3) @(negedge clk);
            start = 1; num_passes = 4'd7;
            @(negedge clk);
            start = 0;
        end
        if (abort) begin
            t = 0;
            while (nw < w0 + 14 && t < 500) begin @(negedge clk); t++; end
            chk("reach_drain", 32'(nw - w0 >= 14), 1);
            #2 rst = 1;
            #1 chk("rst_outs", {busy, rd_en, wr_en, filt_en, frame_done, rd_buf, pass_idx}, 0);
            sbq.delete();
            exp_rb = 0;
            @(negedge clk);
            rst = 0;
            repeat (30) @(negedge clk);
            chk("no_done_after_rst", ndone - d0, 0);
            chk("idle_after_rst", 32'(busy), 0);
            return;
        end
        t = 0;
        while (!frame_done && t < 1000) begin @(negedge clk); t++; end
        chk("done_seen", 32'(frame_done), 1);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_low", 32'(busy), 0);
        chk("done_cnt", ndone - d0, 1);
        chk("wr_cnt", nw - w0, N * n);
        chk("sb_left", sbq.size(), 0);
        exp_rb ^= n[0];
        chk("rd_buf_end", 32'(rd_buf), 32'(exp_rb));
        repeat (2) @(negedge clk);
        chk("idle_stays", 32'(busy), 0);
    endtask

    initial begin
        img_t im;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", {rd_en, wr_en, filt_en, frame_done}, 0);
        chk("rst_pass_buf", {rd_buf, pass_idx}, 0);
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) im[i] = 8'(i * 15);
        run_job(im, 1, 0, 0, 0);
        run_job(rimg(), 3, 0, 0, 0);
        for (int i = 0; i < N; i++) im[i] = 8'hFF;
        run_job(im, 1, 1, 0, 0);
        run_job(rimg(), 1, 0, 0, 1);
        run_job(rimg(), 2, 1, 0, 0);
        run_job(rimg(), 1, 0, 1, 0);
        run_job(rimg(), 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) run_job(rimg(), $urandom_range(1, 3), 1'($urandom), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
